// File: rtl/tabela_verdade_prog.sv
`default_nettype none
// ============================================================================
// Module      : tabela_verdade_prog
// Description : Programmable N-input truth table with a registered output.
//               The active table is replaced by shifting in 2^N bits (index 0
//               first) into a shadow copy. The shadow copy is committed to the
//               active table in one step only after the last bit is accepted.
// Ports       : clk, rst        - single rising-edge clock, sync active-high reset
//               entrada[N-1:0]  - table index (MSB is the first variable)
//               load_start      - request a table reload (ignored while loading)
//               load_valid/bit  - serial table bit handshake with load_ready
//               load_ready      - high while the block accepts table bits
//               S, S_valid      - registered table output and its qualifier
//               cont_um[15:0]   - saturating count of RUN edges registering S=1
//                                 (present only when TABELA_CONT_EN is defined)
// Options     : `define TABELA_CONT_EN to add the cont_um counter and port.
// Revision    : 1.0 - initial release
// ============================================================================
module tabela_verdade_prog #(
    parameter int                N           = 3,
    parameter logic [(1<<N)-1:0] TABELA_INIT = 8'h63
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] entrada,
    input  logic         load_start,
    input  logic         load_valid,
    input  logic         load_bit,
    output logic         load_ready,
    output logic         S,
    output logic         S_valid
`ifdef TABELA_CONT_EN
    ,
    output logic [15:0]  cont_um
`endif
);

    localparam int C_TAM = 1 << N;
    // One extra bit so the count of accepted bits can reach 2^N without wrapping.
    localparam int C_IW  = N + 1;
    localparam logic [C_IW-1:0] C_ULTIMO = C_IW'(C_TAM - 1);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t             r_state_q,   w_state_d;
    logic [C_TAM-1:0]   r_tab_q,     w_tab_d;
    logic [C_TAM-1:0]   r_shadow_q,  w_shadow_d;
    logic [C_IW-1:0]    r_idx_q,     w_idx_d;
    logic               r_s_q,       w_s_d;
    logic               r_s_valid_q, w_s_valid_d;
    logic               r_ready_q,   w_ready_d;
    logic               w_commit;

    always_comb begin
        w_state_d   = r_state_q;
        w_tab_d     = r_tab_q;
        w_shadow_d  = r_shadow_q;
        w_idx_d     = r_idx_q;
        w_s_d       = r_s_q;
        w_s_valid_d = r_s_valid_q;
        w_ready_d   = r_ready_q;
        w_commit    = 1'b0;

        case (r_state_q)
            RUN: begin
                // Evaluation happens on every RUN edge, including the one
                // that moves to LOAD, so the last output reflects the old table.
                w_s_d       = r_tab_q[entrada];
                w_s_valid_d = 1'b1;
                w_ready_d   = 1'b0;
                if (load_start) begin
                    w_state_d   = LOAD;
                    w_idx_d     = '0;
                    w_ready_d   = 1'b1;
                    w_s_valid_d = 1'b0;
                end
            end
            LOAD: begin
                // S holds its value; load_start is deliberately not examined.
                w_s_valid_d = 1'b0;
                if (load_valid && r_ready_q) begin
                    w_shadow_d[r_idx_q[N-1:0]] = load_bit;
                    w_idx_d                    = r_idx_q + 1'b1;
                    if (r_idx_q == C_ULTIMO) begin
                        // Commit includes the bit accepted on this very edge.
                        w_tab_d   = w_shadow_d;
                        w_state_d = RUN;
                        w_ready_d = 1'b0;
                        w_commit  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= RUN;
            r_tab_q     <= TABELA_INIT;
            r_shadow_q  <= '0;
            r_idx_q     <= '0;
            r_s_q       <= 1'b0;
            r_s_valid_q <= 1'b0;
            r_ready_q   <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_tab_q     <= w_tab_d;
            r_shadow_q  <= w_shadow_d;
            r_idx_q     <= w_idx_d;
            r_s_q       <= w_s_d;
            r_s_valid_q <= w_s_valid_d;
            r_ready_q   <= w_ready_d;
        end
    end

    assign load_ready = r_ready_q;
    assign S          = r_s_q;
    assign S_valid    = r_s_valid_q;

`ifdef TABELA_CONT_EN
    logic [15:0] r_cont_q, w_cont_d;

    always_comb begin
        w_cont_d = r_cont_q;
        if (w_commit) begin
            w_cont_d = '0;
        end else if ((r_state_q == RUN) && w_s_d && (r_cont_q != 16'hFFFF)) begin
            w_cont_d = r_cont_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cont_q <= '0;
        end else begin
            r_cont_q <= w_cont_d;
        end
    end

    assign cont_um = r_cont_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tabela_verdade_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_tabela_verdade_prog
// Description : Self-checking bench for tabela_verdade_prog (N=3). Sweeps use
//               a vector table and an expected-value queue; reload, wait-state,
//               restart and mid-load reset cases are hand-written sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tabela_verdade_prog;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] entrada;
    logic       load_start;
    logic       load_valid;
    logic       load_bit;
    logic       load_ready;
    logic       S;
    logic       S_valid;
`ifdef TABELA_CONT_EN
    logic [15:0] cont_um;
`endif

    always #5 clk = ~clk;

    tabela_verdade_prog #(
        .N           (3),
        .TABELA_INIT (8'h63)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .entrada    (entrada),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_bit   (load_bit),
        .load_ready (load_ready),
        .S          (S),
        .S_valid    (S_valid)
`ifdef TABELA_CONT_EN
        ,
        .cont_um    (cont_um)
`endif
    );

    typedef struct {
        logic [2:0] ent;
        logic       exp_s;
    } vec_t;

    vec_t vecs[16];
    logic exp_q[$];
    logic [7:0] model_tab;
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nome, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Applies vecs[base..base+7]; the expected S is queued when driven and
    // popped one edge later when the DUT registers it.
    task automatic sweep_vec(input int base, input string nome);
        logic e;
        for (int i = 0; i < 8; i++) begin
            entrada = vecs[base+i].ent;
            exp_q.push_back(vecs[base+i].exp_s);
            tick();
            e = exp_q.pop_front();
            chk({nome, " S"}, 32'(S), 32'(e));
            chk({nome, " S_valid"}, 32'(S_valid), 32'd1);
        end
    endtask

    task automatic sweep_model(input string nome);
        logic e;
        for (int i = 0; i < 8; i++) begin
            entrada = 3'(i);
            exp_q.push_back(model_tab[i]);
            tick();
            e = exp_q.pop_front();
            chk({nome, " S"}, 32'(S), 32'(e));
            chk({nome, " S_valid"}, 32'(S_valid), 32'd1);
        end
    endtask

    // Full reload of 8 bits with entrada held. gaps inserts a load_valid=0
    // cycle after each bit; restart_at reasserts load_start with that bit.
    task automatic load_tab(input logic [7:0] bits, input bit gaps, input int restart_at,
                            input string nome);
        logic held;
        held       = model_tab[entrada];
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk({nome, " enter ready"}, 32'(load_ready), 32'd1);
        chk({nome, " enter S_valid"}, 32'(S_valid), 32'd0);
        chk({nome, " last RUN eval"}, 32'(S), 32'(held));
        for (int i = 0; i < 8; i++) begin
            load_valid = 1'b1;
            load_bit   = bits[i];
            load_start = (i == restart_at);
            tick();
            load_start = 1'b0;
            if (i < 7) begin
                chk({nome, " ready mid"}, 32'(load_ready), 32'd1);
                chk({nome, " S held"}, 32'(S), 32'(held));
                chk({nome, " S_valid mid"}, 32'(S_valid), 32'd0);
                if (gaps) begin
                    load_valid = 1'b0;
                    load_bit   = ~bits[i];
                    tick();
                    chk({nome, " S held gap"}, 32'(S), 32'(held));
                    chk({nome, " ready gap"}, 32'(load_ready), 32'd1);
                end
            end
        end
        load_valid = 1'b0;
        chk({nome, " commit ready"}, 32'(load_ready), 32'd0);
        chk({nome, " commit S_valid"}, 32'(S_valid), 32'd0);
        chk({nome, " commit S held"}, 32'(S), 32'(held));
`ifdef TABELA_CONT_EN
        chk({nome, " cont_um cleared"}, 32'(cont_um), 32'd0);
`endif
        model_tab = bits;
        tick();
        chk({nome, " first new eval"}, 32'(S), 32'(bits[entrada]));
        chk({nome, " S_valid back"}, 32'(S_valid), 32'd1);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        model_tab = 8'h63;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Default table 0x63 expected outputs, written out literally.
        vecs[0]  = '{3'd0, 1'b1}; vecs[1]  = '{3'd1, 1'b1};
        vecs[2]  = '{3'd2, 1'b0}; vecs[3]  = '{3'd3, 1'b0};
        vecs[4]  = '{3'd4, 1'b0}; vecs[5]  = '{3'd5, 1'b1};
        vecs[6]  = '{3'd6, 1'b1}; vecs[7]  = '{3'd7, 1'b0};
        // Table loaded with bits 1,0,0,0,0,0,0,1: only indexes 0 and 7 are 1.
        vecs[8]  = '{3'd0, 1'b1}; vecs[9]  = '{3'd1, 1'b0};
        vecs[10] = '{3'd2, 1'b0}; vecs[11] = '{3'd3, 1'b0};
        vecs[12] = '{3'd4, 1'b0}; vecs[13] = '{3'd5, 1'b0};
        vecs[14] = '{3'd6, 1'b0}; vecs[15] = '{3'd7, 1'b1};

        rst        = 1'b1;
        entrada    = 3'd0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_bit   = 1'b0;
        model_tab  = 8'h63;
        tick();
        tick();
        chk("reset S", 32'(S), 32'd0);
        chk("reset S_valid", 32'(S_valid), 32'd0);
        chk("reset load_ready", 32'(load_ready), 32'd0);
`ifdef TABELA_CONT_EN
        chk("reset cont_um", 32'(cont_um), 32'd0);
`endif
        rst = 1'b0;

        // Default-table sweep, run twice (16 evaluation edges).
        sweep_vec(0, "default sweep");
        sweep_vec(0, "default sweep2");
`ifdef TABELA_CONT_EN
        chk("cont_um after 16", 32'(cont_um), 32'd8);
`endif

        // RUN ignores load_valid/load_bit.
        entrada    = 3'd2;
        load_valid = 1'b1;
        load_bit   = 1'b1;
        tick();
        load_valid = 1'b0;
        chk("run ignores load S", 32'(S), 32'd0);
        chk("run ignores load ready", 32'(load_ready), 32'd0);

        // Reload with continuous valid, then sweep the new table.
        entrada = 3'd0;
        load_tab(8'h81, 1'b0, -1, "load 81");
        sweep_vec(8, "table 81 sweep");

        // Reset restores the init table; reload with wait states at entrada=7.
        do_reset();
        entrada = 3'd7;
        load_tab(8'h81, 1'b1, -1, "load gaps");

        // load_start reasserted on the 3rd bit must not restart the index.
        entrada = 3'd5;
        load_tab(8'hA5, 1'b0, 2, "load restart");
        sweep_model("table A5 sweep");

        // Reset after 4 accepted bits, with load_start/load_valid also high.
        entrada    = 3'd5;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_bit   = 1'b0;
            tick();
        end
        rst        = 1'b1;
        load_start = 1'b1;
        load_valid = 1'b1;
        tick();
        rst        = 1'b0;
        load_start = 1'b0;
        load_valid = 1'b0;
        model_tab  = 8'h63;
        chk("midload rst ready", 32'(load_ready), 32'd0);
        chk("midload rst S_valid", 32'(S_valid), 32'd0);
        chk("midload rst S", 32'(S), 32'd0);
        tick();
        chk("after rst S(101)", 32'(S), 32'd1);
        chk("after rst S_valid", 32'(S_valid), 32'd1);
        chk("after rst ready", 32'(load_ready), 32'd0);
        sweep_vec(0, "restored sweep");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
